// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage and architectural register file.
//
// Takes the MEM/WB register outputs, selects the writeback value, and
// commits it into a 2**ADDR_W entry register file. Two combinational read
// ports serve the ID stage. A write in the current cycle is bypassed to
// those ports, so the ID stage sees the new value in the cycle it commits.
// Register 0 always reads as zero. A retire counter and the PC of the last
// committed writeback are kept for debug.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active low
//   wb_en_i       writeback valid from MEM/WB
//   mem_to_reg_i  1 = write read_data_i, 0 = write alu_res_i
//   pc_i          PC of the instruction in WB
//   alu_res_i     ALU result from MEM/WB
//   read_data_i   load data from MEM/WB
//   rd_addr_i     destination register index
//   rs_addr_i     read port A index
//   rt_addr_i     read port B index
//   rs_data_o     read port A data (combinational, with bypass)
//   rt_data_o     read port B data (combinational, with bypass)
//   wb_data_o     selected writeback value (combinational, to forwarding)
//   retire_cnt_o  number of cycles with wb_en_i=1, wraps
//   last_pc_o     pc_i of the most recent cycle with wb_en_i=1
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_en_i,
  input  logic              mem_to_reg_i,
  input  logic [31:0]       pc_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic [31:0]       last_pc_o
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              reg_we;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] load_data,
    input logic [DATA_W-1:0] alu_res
  );
    return mem_to_reg ? load_data : alu_res;
  endfunction

  assign wb_data_o = wb_select(mem_to_reg_i, read_data_i, alu_res_i);

  // Index 0 is never written; its storage stays at its reset value.
  assign reg_we = wb_en_i && (rd_addr_i != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_we) begin
      regs[rd_addr_i] <= wb_data_o;
    end
  end

  // Retire bookkeeping counts every valid writeback, including those to
  // register 0, since the instruction still retired.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retire_cnt_o <= '0;
      last_pc_o    <= '0;
    end else if (wb_en_i) begin
      retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      last_pc_o    <= pc_i;
    end
  end

  // Read ports: zero for index 0 first, then the write-before-read bypass,
  // then the stored value.
  always_comb begin
    rs_data_o = regs[rs_addr_i];
    if (rs_addr_i == '0) begin
      rs_data_o = '0;
    end else if (reg_we && (rd_addr_i == rs_addr_i)) begin
      rs_data_o = wb_data_o;
    end
  end

  always_comb begin
    rt_data_o = regs[rt_addr_i];
    if (rt_addr_i == '0) begin
      rt_data_o = '0;
    end else if (reg_we && (rd_addr_i == rt_addr_i)) begin
      rt_data_o = wb_data_o;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int NREG   = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              wb_en_i;
  logic              mem_to_reg_i;
  logic [31:0]       pc_i;
  logic [DATA_W-1:0] alu_res_i;
  logic [DATA_W-1:0] read_data_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [ADDR_W-1:0] rs_addr_i;
  logic [ADDR_W-1:0] rt_addr_i;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [CNT_W-1:0]  retire_cnt_o;
  logic [31:0]       last_pc_o;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_en_i(wb_en_i), .mem_to_reg_i(mem_to_reg_i),
    .pc_i(pc_i), .alu_res_i(alu_res_i), .read_data_i(read_data_i),
    .rd_addr_i(rd_addr_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .wb_data_o(wb_data_o),
    .retire_cnt_o(retire_cnt_o), .last_pc_o(last_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: architectural state as plain integers and an array.
  logic [31:0] m_regs [NREG];
  int unsigned m_cnt;
  logic [31:0] m_pc;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wb();
    return mem_to_reg_i ? read_data_i : alu_res_i;
  endfunction

  // What ID should see at a read index this cycle: x0 is zero, a committing
  // write to the same index is visible immediately, otherwise stored state.
  function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return 32'h0;
    if (rst_i && wb_en_i && rd_addr_i == a) return m_wb();
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
    m_cnt = 0;
    m_pc  = 32'h0;
  endtask

  // Drive one set of WB/ID inputs and check the combinational outputs.
  task automatic apply(input logic en, input logic mtr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    wb_en_i = en; mem_to_reg_i = mtr; pc_i = pc; alu_res_i = alu;
    read_data_i = ld; rd_addr_i = rd; rs_addr_i = rs; rt_addr_i = rt;
    #1;
    chk("wb_data", wb_data_o, m_wb());
    chk("rs_data", rs_data_o, m_read(rs_addr_i));
    chk("rt_data", rt_data_o, m_read(rt_addr_i));
  endtask

  // Clock edge: advance the model and check the registered outputs.
  task automatic tick();
    @(posedge clk_i);
    if (rst_i && wb_en_i) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_pc  = pc_i;
      if (rd_addr_i != 0) m_regs[rd_addr_i] = m_wb();
    end
    #1;
    chk("retire_cnt", 32'(retire_cnt_o), m_cnt);
    chk("last_pc", last_pc_o, m_pc);
  endtask

  // Asynchronous reset pulse between edges, held across one edge with a
  // write offered (which must be ignored).
  task automatic do_reset();
    wb_en_i = 1'b0;
    #1;
    rst_i = 1'b0;
    #1;
    m_reset();
    chk("rst_cnt_async", 32'(retire_cnt_o), 32'h0);
    chk("rst_pc_async", last_pc_o, 32'h0);
    for (int i = 0; i < NREG; i++) begin
      rs_addr_i = 5'(i);
      rt_addr_i = 5'(NREG - 1 - i);
      #1;
      chk("rst_rs", rs_data_o, 32'h0);
      chk("rst_rt", rt_data_o, 32'h0);
    end
    wb_en_i = 1'b1; rd_addr_i = 5'd3; alu_res_i = 32'h5555_0000; mem_to_reg_i = 1'b0;
    pc_i = 32'h0000_0F00;
    tick();
    rs_addr_i = 5'd3;
    wb_en_i = 1'b0;
    #1;
    chk("rst_hold_reg3", rs_data_o, 32'h0);
    rst_i = 1'b1;
  endtask

  logic [31:0] cnt_before;

  initial begin
    rst_i = 1'b1;
    wb_en_i = 0; mem_to_reg_i = 0; pc_i = 0; alu_res_i = 32'hFACE_0001;
    read_data_i = 32'hFACE_0002; rd_addr_i = 0; rs_addr_i = 0; rt_addr_i = 0;
    m_reset();
    @(posedge clk_i);
    #2;

    // Reset behaviour.
    do_reset();

    // ALU write to r5, visible next cycle.
    apply(1, 0, 32'h40, 32'h1234_5678, 32'h0, 5'd5, 5'd0, 5'd0);
    tick();
    chk("t2_cnt", 32'(retire_cnt_o), 32'd1);
    chk("t2_pc", last_pc_o, 32'h40);
    apply(0, 0, 32'h44, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    chk("t2_rs", rs_data_o, 32'h1234_5678);

    // Load write with same-cycle bypass on both ports.
    apply(1, 1, 32'h48, 32'h1, 32'hDEAD_BEEF, 5'd7, 5'd7, 5'd7);
    chk("t3_rs_bypass", rs_data_o, 32'hDEAD_BEEF);
    chk("t3_rt_bypass", rt_data_o, 32'hDEAD_BEEF);
    tick();
    apply(0, 0, 32'h4C, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    chk("t3_rs_hold", rs_data_o, 32'hDEAD_BEEF);
    chk("t3_rt_hold", rt_data_o, 32'hDEAD_BEEF);

    // Writes to x0 are discarded but still retire.
    cnt_before = 32'(retire_cnt_o);
    apply(1, 0, 32'h50, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("t4_rs_bypass", rs_data_o, 32'h0);
    tick();
    chk("t4_cnt", 32'(retire_cnt_o), (cnt_before + 1) % 16);
    apply(0, 0, 32'h54, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("t4_rs_after", rs_data_o, 32'h0);

    // Disabled write changes nothing.
    cnt_before = 32'(retire_cnt_o);
    apply(0, 0, 32'h58, 32'hAAAA_AAAA, 32'h0, 5'd5, 5'd5, 5'd5);
    chk("t5_wb_data", wb_data_o, 32'hAAAA_AAAA);
    chk("t5_rs", rs_data_o, 32'h1234_5678);
    tick();
    chk("t5_cnt", 32'(retire_cnt_o), cnt_before);
    chk("t5_pc", last_pc_o, 32'h50);
    apply(0, 0, 32'h5C, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    chk("t5_reg5", rs_data_o, 32'h1234_5678);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      apply(1, 0, 32'(i * 4), 32'(i), 32'h0, 5'd0, 5'd0, 5'd0);
      tick();
      if (i == 15) chk("t6_cnt15", 32'(retire_cnt_o), 32'd15);
      if (i == 16) chk("t6_cnt16", 32'(retire_cnt_o), 32'd0);
      if (i == 17) chk("t6_cnt17", 32'(retire_cnt_o), 32'd1);
    end

    // Randomized traffic, with occasional resets mid-stream.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      apply(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom(),
            $urandom(), $urandom(), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
